// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: skid/elastic buffer between two pipeline stages.
// Entries live in a small circular buffer. Both handshake outputs come
// straight from registers, so there is no combinational path through the
// stage in either direction. A saturating counter records downstream stalls.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_CNT  = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  // Data storage has no reset: out_data is only meaningful while out_valid=1.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [OCC_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_push;
  logic              w_pop;
  logic              w_stall;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [PTR_W-1:0]  w_wr_ptr_nxt;

  // Handshake outputs depend on registered count only.
  assign in_ready  = (r_count < FULL_CNT);
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign occupancy = r_count;
  assign stall_cnt = r_stall_cnt;

  // A full buffer refuses a push even when a pop happens in the same cycle,
  // because in_ready must not look at out_ready.
  assign w_push  = in_valid & in_ready;
  assign w_pop   = out_valid & out_ready;
  assign w_stall = out_valid & ~out_ready & ~flush_i;

  // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of 2).
  assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
  assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);

  // Store accepted entries; a flush cycle writes nothing so contents persist.
  always_ff @(posedge clk) begin
    if (w_push && !flush_i) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointer and count update; flush overrides any push or pop that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating stall counter; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width in bits of the flattened stage bundle carried per entry.
REQ-002 SHALL have parameter DEPTH, default 2: number of buffered entries; legal range 2..16.
REQ-003 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i, input, 1: synchronous flush; discards all held entries.
REQ-007 SHALL have port in_valid, input, 1: upstream stage offers in_data.
REQ-008 SHALL have port in_ready, output, 1: buffer accepts in_data this cycle.
REQ-009 SHALL have port in_data, input, DATA_W: upstream bundle.
REQ-010 SHALL have port out_valid, output, 1: out_data holds a valid bundle.
REQ-011 SHALL have port out_ready, input, 1: downstream stage consumes out_data this cycle.
REQ-012 SHALL have port out_data, output, DATA_W: oldest held bundle.
REQ-013 SHALL have port occupancy, output, $clog2(DEPTH+1): number of held entries.
REQ-014 SHALL have port stall_cnt, output, CNT_W: cycles with out_valid=1 and out_ready=0.

Function
REQ-015 SHALL hold entries in a circular buffer with read pointer, write pointer and count registers; pointers wrap from DEPTH-1 to 0.
REQ-016 SHALL accept an entry on a rising edge where in_valid=1 and in_ready=1, i.e. push.
REQ-017 SHALL release an entry on a rising edge where out_valid=1 and out_ready=1, i.e. pop.
REQ-018 SHALL drive in_ready = (count < DEPTH), from registered state only; no combinational path from out_ready to in_ready.
REQ-019 SHALL drive out_valid = (count != 0) and out_data = entry at read pointer, from registered state only; no combinational path from in_* to out_*.
REQ-020 SHALL have a latency of exactly 1 cycle: an entry pushed into an empty buffer appears on out_data with out_valid=1 on the next cycle.
REQ-021 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-022 SHALL, when full, not accept a push even if out_ready=1 in the same cycle; in_ready returns to 1 the cycle after the pop.
REQ-023 SHALL sustain one transfer per cycle when DEPTH>=2 and out_ready is held at 1.
REQ-024 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, when flush_i=1 at a rising edge, set count, read pointer and write pointer to 0, ignoring any push or pop in that cycle.
REQ-026 SHALL leave stored data contents unchanged by a flush; only control state is cleared.
REQ-027 SHALL increment stall_cnt by 1 on each rising edge where out_valid=1, out_ready=0 and flush_i=0.
REQ-028 SHALL saturate stall_cnt at 2^CNT_W-1 with no wrap to 0.
REQ-029 SHALL not clear stall_cnt on flush; only reset clears it.
REQ-030 SHALL drive occupancy equal to count at all times.

Reset
REQ-031 SHALL, while rst_n=0, immediately drive count=0, both pointers=0, stall_cnt=0, out_valid=0, occupancy=0 and in_ready=1, independent of clk.
REQ-032 SHALL, after reset deasserts mid-transfer, discard all prior entries; data storage needs no reset and out_data is don't-care while out_valid=0.

Verification
REQ-033 SHALL be verified with the streaming scenario: DEPTH=2, out_ready=1, push 0x11..0x18 on consecutive cycles -> out_data sequence 0x11..0x18, each one cycle after its push, in_ready constantly 1.
REQ-034 SHALL be verified with the backpressure scenario: out_ready=0, push 0xA, 0xB, 0xC -> 0xC not accepted, in_ready=0, occupancy=2, out_data=0xA stable; raise out_ready -> 0xA then 0xB output, in_ready=1 one cycle after the first pop.
REQ-035 SHALL be verified with the flush scenario: occupancy=2, flush_i=1 together with in_valid=1 and out_ready=1 -> next cycle occupancy=0, out_valid=0, no pop counted, flushed-cycle data never output.
REQ-036 SHALL be verified with the stall saturation scenario: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and holds; a following flush leaves it at 15.
REQ-037 SHALL be verified with the wrap scenario: DEPTH=3, random in_valid/out_ready for 1000 cycles against a reference queue -> order preserved, no loss or duplication, pointers wrapping more than 100 times.
REQ-038 SHALL be verified with the async reset scenario: assert rst_n=0 between clock edges while occupancy=2 -> out_valid=0, occupancy=0 and stall_cnt=0 before the next edge.
